trap_csr_unit: RTL

Parametrised machine-mode trap and CSR unit for the RV32I core. It replaces the fixed 16-line fast-IRQ CSR block. It adds a configurable fast-IRQ channel count, per-channel edge or level sensing, mtval, 64-bit mcycle/minstret counters, and a one-cycle trap-entry FSM with an explicit trap_req pulse. It sits beside the pipeline: CSR reads come from EX, CSR writes and mret from WB, and trap_req/trap_addr go to IF for redirect and flush.

---
 rtl/trap_csr_pkg.sv | 38 +++
 rtl/trap_csr_unit_irq_prio_enc.sv | 23 ++
 rtl/trap_csr_unit.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/trap_csr_pkg.sv
// trap_csr_pkg: CSR addresses, cause codes, trap FSM states, mtvec modes and the counter update helper
package trap_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    localparam logic [4:0] CAUSE_MSI = 5'd3;
    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MEI = 5'd11;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    typedef enum logic [0:0] {IDLE = 1'b0, ENTER = 1'b1} state_e;

    // A write to one half replaces it and suppresses the carry into the other half.
    function automatic logic [63:0] cnt_next(input logic [63:0] cur, input logic inc,
                                             input logic we_lo, input logic we_hi,
                                             input logic [31:0] wd);
        return we_lo ? {cur[63:32], wd} :
               we_hi ? {wd, cur[31:0] + 32'(inc)} : cur + 64'(inc);
    endfunction

endpackage

// File: rtl/trap_csr_unit_irq_prio_enc.sv
// irq_prio_enc: lowest-index-first priority encoder
//   i_req   : request vector
//   o_valid : any request set
//   o_idx   : index of the lowest set request
module irq_prio_enc
    import trap_csr_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [N-1:0] i_req,
    output logic         o_valid,
    output logic [3:0]   o_idx
);

    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (i_req[i]) o_idx = 4'(i);
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/trap_csr_unit.sv
// trap_csr_unit: machine-mode trap entry FSM, interrupt sensing and CSR file
//   clk, reset                : clock, asynchronous active-high reset
//   i_meip/i_mtip/i_msip      : standard interrupt levels
//   i_fast_irq                : fast interrupt channels (edge or level per EDGE_MASK)
//   i_exc_*                   : synchronous exception with cause, pc and tval
//   i_irq_pc                  : pc saved on interrupt entry
//   i_instr_retire            : minstret increment
//   i_csr_raddr / o_csr_rdata : combinational CSR read port
//   i_csr_we/waddr/wdata      : CSR write port
//   i_mret                    : return from trap
//   o_trap_req / o_trap_addr  : one-cycle redirect pulse and handler address
//   o_mepc                    : aligned mepc for mret redirect
//   o_irq_ack / o_irq_ack_id  : interrupt acknowledge pulse and cause code
module trap_csr_unit
    import trap_csr_pkg::*;
#(
    parameter int          NUM_FAST    = 16,
    parameter logic [15:0] EDGE_MASK   = 16'h0000,
    parameter bit          VECTORED_EN = 1'b1,
    parameter bit          COUNTERS_EN = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_meip,
    input  logic                i_mtip,
    input  logic                i_msip,
    input  logic [NUM_FAST-1:0] i_fast_irq,
    input  logic                i_exc_valid,
    input  logic [4:0]          i_exc_cause,
    input  logic [31:0]         i_exc_pc,
    input  logic [31:0]         i_exc_tval,
    input  logic [31:0]         i_irq_pc,
    input  logic                i_instr_retire,
    input  logic [11:0]         i_csr_raddr,
    output logic [31:0]         o_csr_rdata,
    input  logic                i_csr_we,
    input  logic [11:0]         i_csr_waddr,
    input  logic [31:0]         i_csr_wdata,
    input  logic                i_mret,
    output logic                o_trap_req,
    output logic [31:0]         o_trap_addr,
    output logic [31:0]         o_mepc,
    output logic                o_irq_ack,
    output logic [4:0]          o_irq_ack_id
);

    localparam logic [NUM_FAST-1:0] EDGE     = EDGE_MASK[NUM_FAST-1:0];
    localparam logic [31:0]         MIE_MASK = 32'h0000_0888 | (32'((64'd1 << NUM_FAST) - 64'd1) << 16);

    state_e              r_state;
    logic                r_mstatus_mie, r_mstatus_mpie;
    logic [31:0]         r_mie, r_mscratch, r_mepc, r_mcause, r_mtval, r_trap_addr;
    logic [31:2]         r_mtvec_base;
    logic [1:0]          r_mtvec_mode;
    logic [63:0]         r_mcycle, r_minstret;
    logic [2:0]          r_irq_q;
    logic [NUM_FAST-1:0] r_fast_q, r_fast_d, r_fast_pend;
    logic                r_ack_irq;
    logic [4:0]          r_ack_id;

    logic [NUM_FAST-1:0] w_fast_mip, w_fast_clr;
    logic [31:0]         w_mip, w_pend, w_base, w_trap_addr, w_epc;
    logic                w_fvalid, w_idle, w_take;
    logic [3:0]          w_fidx;
    logic [4:0]          w_irq_code, w_code;

    assign w_idle     = r_state == IDLE;
    assign w_fast_mip = (EDGE & r_fast_pend) | (~EDGE & r_fast_q);
    // r_irq_q = {meip, mtip, msip} placed at mip bits 11, 7, 3
    assign w_mip      = (32'(w_fast_mip) << 16) |
                        {20'b0, r_irq_q[2], 3'b0, r_irq_q[1], 3'b0, r_irq_q[0], 3'b0};
    assign w_pend     = w_mip & r_mie & {32{r_mstatus_mie}};

    irq_prio_enc #(.N(NUM_FAST)) u_prio (
        .i_req   (w_pend[16 +: NUM_FAST]),
        .o_valid (w_fvalid),
        .o_idx   (w_fidx)
    );

    assign w_irq_code  = w_pend[11] ? CAUSE_MEI : w_pend[3] ? CAUSE_MSI :
                         w_pend[7]  ? CAUSE_MTI : w_fvalid ? {1'b1, w_fidx} : 5'd0;
    assign w_take      = w_idle & (i_exc_valid | (|w_pend));
    assign w_code      = i_exc_valid ? i_exc_cause : w_irq_code;
    assign w_base      = {r_mtvec_base, 2'b00};
    assign w_trap_addr = (r_mtvec_mode == MTVEC_VECTORED && !i_exc_valid) ?
                         w_base + {25'b0, w_code, 2'b00} : w_base;
    assign w_epc       = (i_exc_valid ? i_exc_pc : i_irq_pc) & ~32'h3;
    // Acknowledging fast channel i (cause 16+i) retires its edge latch.
    assign w_fast_clr  = (!w_idle && r_ack_irq && r_ack_id[4]) ? NUM_FAST'(1) << r_ack_id[3:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= IDLE;
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
            r_trap_addr    <= '0;
            r_mtvec_base   <= '0;
            r_mtvec_mode   <= MTVEC_DIRECT;
            r_mcycle       <= '0;
            r_minstret     <= '0;
            r_irq_q        <= '0;
            r_fast_q       <= '0;
            r_fast_d       <= '0;
            r_fast_pend    <= '0;
            r_ack_irq      <= 1'b0;
            r_ack_id       <= '0;
        end else begin
            r_irq_q     <= {i_meip, i_mtip, i_msip};
            r_fast_q    <= i_fast_irq;
            r_fast_d    <= r_fast_q;
            r_fast_pend <= ((r_fast_pend & ~w_fast_clr) | (r_fast_q & ~r_fast_d)) & EDGE;
            r_state     <= w_take ? ENTER : IDLE;
            if (w_take) begin
                r_ack_irq   <= ~i_exc_valid;
                r_ack_id    <= w_code;
                r_trap_addr <= w_trap_addr;
            end
            if (i_csr_we && i_csr_waddr == CSR_MIE)
                r_mie <= i_csr_wdata & MIE_MASK;
            if (i_csr_we && i_csr_waddr == CSR_MTVEC) begin
                r_mtvec_base <= i_csr_wdata[31:2];
                r_mtvec_mode <= (VECTORED_EN && i_csr_wdata[1:0] == MTVEC_VECTORED) ? MTVEC_VECTORED : MTVEC_DIRECT;
            end
            if (i_csr_we && i_csr_waddr == CSR_MSCRATCH)
                r_mscratch <= i_csr_wdata;
            // Trap entry owns mstatus/mepc/mcause/mtval and drops a coincident mret.
            if (w_take) begin
                r_mepc         <= w_epc;
                r_mcause       <= {~i_exc_valid, 26'b0, w_code};
                r_mtval        <= i_exc_valid ? i_exc_tval : '0;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else begin
                if (i_csr_we && i_csr_waddr == CSR_MSTATUS) begin
                    r_mstatus_mie  <= i_csr_wdata[3];
                    r_mstatus_mpie <= i_csr_wdata[7];
                end
                if (i_csr_we && i_csr_waddr == CSR_MEPC)
                    r_mepc <= i_csr_wdata & ~32'h3;
                if (i_csr_we && i_csr_waddr == CSR_MCAUSE)
                    r_mcause <= i_csr_wdata;
                if (i_csr_we && i_csr_waddr == CSR_MTVAL)
                    r_mtval <= i_csr_wdata;
                if (i_mret && w_idle) begin
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                end
            end
            if (COUNTERS_EN) begin
                r_mcycle   <= cnt_next(r_mcycle, 1'b1,
                                       i_csr_we && i_csr_waddr == CSR_MCYCLE,
                                       i_csr_we && i_csr_waddr == CSR_MCYCLEH, i_csr_wdata);
                r_minstret <= cnt_next(r_minstret, i_instr_retire,
                                       i_csr_we && i_csr_waddr == CSR_MINSTRET,
                                       i_csr_we && i_csr_waddr == CSR_MINSTRETH, i_csr_wdata);
            end
        end
    end

    always_comb begin
        case (i_csr_raddr)
            CSR_MSTATUS:                o_csr_rdata = {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
            CSR_MIE:                    o_csr_rdata = r_mie;
            CSR_MTVEC:                  o_csr_rdata = {r_mtvec_base, r_mtvec_mode};
            CSR_MSCRATCH:               o_csr_rdata = r_mscratch;
            CSR_MEPC:                   o_csr_rdata = r_mepc;
            CSR_MCAUSE:                 o_csr_rdata = r_mcause;
            CSR_MTVAL:                  o_csr_rdata = r_mtval;
            CSR_MIP:                    o_csr_rdata = w_mip;
            CSR_MCYCLE,   CSR_CYCLE:    o_csr_rdata = r_mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:   o_csr_rdata = r_mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:  o_csr_rdata = r_minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: o_csr_rdata = r_minstret[63:32];
            default:                    o_csr_rdata = '0;
        endcase
    end

    assign o_trap_req   = r_state == ENTER;
    assign o_trap_addr  = r_trap_addr;
    assign o_mepc       = r_mepc;
    assign o_irq_ack    = o_trap_req & r_ack_irq;
    assign o_irq_ack_id = o_irq_ack ? r_ack_id : 5'd0;

endmodule
